// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types and constants for the change dispenser
package vm_pkg;

    // Change code: 0..4 select 0/5/10/15/20 cents in nickel units; 5..7 illegal.
    typedef logic [2:0] change_code_t;

    localparam logic [4:0]   NICKEL   = 5'd5;
    localparam logic [4:0]   DIME     = 5'd10;
    localparam change_code_t MAX_CODE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EJECT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_e;

    function automatic logic is_legal(input change_code_t code);
        return code <= MAX_CODE;
    endfunction

endpackage

// File: rtl/ack_timer.sv
// rtl/ack_timer.sv - per-coin acknowledge wait counter
//
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   clear_i    force count to zero (priority over enable)
//   enable_i   count one waited cycle
//   expired_o  high during the ACK_TIMEOUT-th waited cycle and after
module ack_timer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count holds the number of cycles already waited, so the current
    // cycle is the last allowed one when count reaches ACK_TIMEOUT-1.
    assign expired_o = (count_q >= CW'(ACK_TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy dime/nickel change dispenser FSM
//
// Ports:
//   clk_i           clock
//   rst_ni          synchronous active-low reset
//   req_i           one-cycle dispense request
//   change_i        change code sampled with req_i
//   coin_ack_i      coin mechanism acknowledge, one per ejected coin
//   eject_dime_o    dime ejector, held until acknowledged
//   eject_nickel_o  nickel ejector, held until acknowledged
//   busy_o          transaction in progress
//   done_o          one-cycle normal completion pulse
//   err_o           one-cycle illegal-code / timeout pulse
//   paid_o          cents ejected in the current/last transaction
module change_dispenser
    import vm_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic [2:0]         change_i,
    input  logic               coin_ack_i,
    output logic               eject_dime_o,
    output logic               eject_nickel_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [4:0]         paid_o
);

    state_e     state_q, state_d;
    logic [2:0] remaining_q, remaining_d;
    logic [4:0] paid_q, paid_d;
    logic       dime_sel;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;

    // Greedy selection: a dime whenever at least two nickels remain.
    assign dime_sel = (remaining_q >= 3'd2);

    // The timer sits at zero whenever we are outside EJECT, so each coin
    // starts its wait from zero.
    assign timer_clear  = (state_q != ST_EJECT);
    assign timer_enable = (state_q == ST_EJECT) && !coin_ack_i;

    ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        paid_d      = paid_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    paid_d = '0;
                    if (is_legal(change_i)) begin
                        remaining_d = change_i;
                        state_d     = (change_i != 3'd0) ? ST_EJECT : ST_DONE;
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_ERROR;
                    end
                end
            end
            ST_EJECT: begin
                // Ack is checked first so an ack on the last allowed cycle wins.
                if (coin_ack_i) begin
                    if (dime_sel) begin
                        remaining_d = remaining_q - 3'd2;
                        paid_d      = paid_q + DIME;
                    end else begin
                        remaining_d = remaining_q - 3'd1;
                        paid_d      = paid_q + NICKEL;
                    end
                    state_d = ST_GAP;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_GAP: begin
                state_d = (remaining_q != 3'd0) ? ST_EJECT : ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                remaining_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            paid_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
        end
    end

    assign eject_dime_o   = (state_q == ST_EJECT) && dime_sel;
    assign eject_nickel_o = (state_q == ST_EJECT) && !dime_sel;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign err_o          = (state_q == ST_ERROR);
    assign paid_o         = paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       req_i;
    logic [2:0] change_i;
    logic       coin_ack_i;
    logic       eject_dime_o;
    logic       eject_nickel_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [4:0] paid_o;

    int total = 0;
    int bad   = 0;
    int both_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_base;
    int err_base;

    change_dispenser #(.ACK_TIMEOUT(15)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .change_i       (change_i),
        .coin_ack_i     (coin_ack_i),
        .eject_dime_o   (eject_dime_o),
        .eject_nickel_o (eject_nickel_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .paid_o         (paid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (eject_dime_o && eject_nickel_o) both_cnt++;
        if (done_o) done_cnt++;
        if (err_o)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then settled and new inputs are set up
    // for the following edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic d, input logic n,
                           input logic b, input logic dn, input logic e,
                           input logic [4:0] p);
        chk({tag, ".dime"},   eject_dime_o,   d);
        chk({tag, ".nickel"}, eject_nickel_o, n);
        chk({tag, ".busy"},   busy_o,         b);
        chk({tag, ".done"},   done_o,         dn);
        chk({tag, ".err"},    err_o,          e);
        chk({tag, ".paid"},   paid_o,         p);
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; change_i = 3'd0; coin_ack_i = 1'b0;
        step(); step();
        chk_out("reset", 0, 0, 0, 0, 0, 5'd0);
        rst_ni = 1'b1;
        step();

        // change 3: dime, gap, nickel, ack two cycles after each eject
        done_base = done_cnt;
        req_i = 1'b1; change_i = 3'd3;
        step(); req_i = 1'b0;
        chk_out("c3.e1", 1, 0, 1, 0, 0, 5'd0);
        step(); step();
        chk_out("c3.e1hold", 1, 0, 1, 0, 0, 5'd0);
        coin_ack_i = 1'b1; step(); coin_ack_i = 1'b0;
        chk_out("c3.gap1", 0, 0, 1, 0, 0, 5'd10);
        step();
        chk_out("c3.e2", 0, 1, 1, 0, 0, 5'd10);
        step(); step();
        coin_ack_i = 1'b1; step(); coin_ack_i = 1'b0;
        chk_out("c3.gap2", 0, 0, 1, 0, 0, 5'd15);
        step();
        chk_out("c3.done", 0, 0, 1, 1, 0, 5'd15);
        step();
        chk_out("c3.idle", 0, 0, 0, 0, 0, 5'd15);
        chk("c3.done_cnt", done_cnt - done_base, 1);

        // illegal code 6: one ERROR cycle, paid cleared, no eject
        err_base = err_cnt;
        req_i = 1'b1; change_i = 3'd6;
        step(); req_i = 1'b0;
        chk_out("c6.err", 0, 0, 1, 0, 1, 5'd0);
        step();
        chk_out("c6.idle", 0, 0, 0, 0, 0, 5'd0);
        chk("c6.err_cnt", err_cnt - err_base, 1);

        // change 0: straight to DONE
        req_i = 1'b1; change_i = 3'd0;
        step(); req_i = 1'b0;
        chk_out("c0.done", 0, 0, 1, 1, 0, 5'd0);
        step();
        chk_out("c0.idle", 0, 0, 0, 0, 0, 5'd0);

        // change 4, second dime never acked: error after 15 waited cycles
        done_base = done_cnt;
        req_i = 1'b1; change_i = 3'd4;
        step(); req_i = 1'b0;
        coin_ack_i = 1'b1; step(); coin_ack_i = 1'b0;
        chk_out("to.gap", 0, 0, 1, 0, 0, 5'd10);
        step();
        chk_out("to.w1", 1, 0, 1, 0, 0, 5'd10);
        for (int i = 0; i < 14; i++) step();
        chk_out("to.w15", 1, 0, 1, 0, 0, 5'd10);
        step();
        chk_out("to.err", 0, 0, 1, 0, 1, 5'd10);
        step();
        chk_out("to.idle", 0, 0, 0, 0, 0, 5'd10);
        chk("to.no_done", done_cnt - done_base, 0);

        // change 4, req during EJECT ignored, ack on the timeout cycle
        done_base = done_cnt;
        req_i = 1'b1; change_i = 3'd4;
        step(); req_i = 1'b0;
        chk_out("aw.w1", 1, 0, 1, 0, 0, 5'd0);
        req_i = 1'b1; change_i = 3'd1;
        step(); req_i = 1'b0;
        for (int i = 0; i < 13; i++) step();
        chk_out("aw.w15", 1, 0, 1, 0, 0, 5'd0);
        coin_ack_i = 1'b1; step(); coin_ack_i = 1'b0;
        chk_out("aw.gap1", 0, 0, 1, 0, 0, 5'd10);
        step();
        chk_out("aw.e2", 1, 0, 1, 0, 0, 5'd10);
        coin_ack_i = 1'b1; step(); coin_ack_i = 1'b0;
        chk_out("aw.gap2", 0, 0, 1, 0, 0, 5'd20);
        step();
        chk_out("aw.done", 0, 0, 1, 1, 0, 5'd20);
        step();
        chk_out("aw.idle", 0, 0, 0, 0, 0, 5'd20);
        chk("aw.done_cnt", done_cnt - done_base, 1);

        // change 2, reset mid-EJECT, then change 1 on the release cycle
        req_i = 1'b1; change_i = 3'd2;
        step(); req_i = 1'b0;
        chk_out("rs.e1", 1, 0, 1, 0, 0, 5'd0);
        rst_ni = 1'b0;
        step();
        chk_out("rs.rst", 0, 0, 0, 0, 0, 5'd0);
        rst_ni = 1'b1; req_i = 1'b1; change_i = 3'd1;
        step(); req_i = 1'b0;
        chk_out("rs.n1", 0, 1, 1, 0, 0, 5'd0);
        coin_ack_i = 1'b1; step(); coin_ack_i = 1'b0;
        chk_out("rs.gap", 0, 0, 1, 0, 0, 5'd5);
        step();
        chk_out("rs.done", 0, 0, 1, 1, 0, 5'd5);
        step();
        chk_out("rs.idle", 0, 0, 0, 0, 0, 5'd5);

        chk("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max cycles an eject line waits for coin_ack_i before abort.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 req_i  input  1  one-cycle dispense request from the vending controller (its soda pulse).
REQ-005 change_i  input  3  change code sampled with req_i: 0..4 = 0/5/10/15/20 cents; 5..7 illegal.
REQ-006 coin_ack_i  input  1  coin mechanism acknowledge, one cycle per ejected coin.
REQ-007 eject_dime_o  output  1  drive dime ejector; held until acknowledged.
REQ-008 eject_nickel_o  output  1  drive nickel ejector; held until acknowledged.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 done_o  output  1  one-cycle pulse when a transaction completes normally.
REQ-011 err_o  output  1  one-cycle pulse on illegal code or ack timeout.
REQ-012 paid_o  output  5  cents ejected so far in current/last transaction (0..20).

Function
REQ-013 The FSM SHALL have states IDLE, EJECT, GAP, DONE, ERROR.
REQ-014 In IDLE, req_i=1 with legal change_i SHALL load remaining = change_i (nickel units), clear paid_o, and go to EJECT if change_i>0, else DONE.
REQ-015 In IDLE, req_i=1 with change_i in 5..7 SHALL go to ERROR without ejecting; paid_o SHALL be cleared.
REQ-016 Coin selection SHALL be greedy: eject_dime_o when remaining>=2, else eject_nickel_o; never both high.
REQ-017 First eject line SHALL assert the cycle after req_i is sampled (latency 1).
REQ-018 In EJECT the selected line SHALL stay high until coin_ack_i=1; that cycle remaining SHALL drop by 2 (dime) or 1 (nickel) and paid_o rise by 10 or 5.
REQ-019 After each ack the FSM SHALL spend exactly one cycle in GAP with both eject lines low, then go to EJECT if remaining>0, else DONE.
REQ-020 coin_ack_i outside EJECT SHALL be ignored.
REQ-021 A per-coin wait counter SHALL clear on EJECT entry; reaching ACK_TIMEOUT cycles without ack SHALL go to ERROR, keeping paid_o as coins actually acked.
REQ-022 DONE SHALL last one cycle with done_o=1, then IDLE; ERROR SHALL last one cycle with err_o=1, then IDLE.
REQ-023 req_i while busy_o=1 SHALL be ignored; current transaction unaffected.
REQ-024 Ack arriving on the timeout cycle SHALL count as success (ack wins).
REQ-025 remaining SHALL be 3 bits, never underflow; paid_o SHALL never exceed 20.

Reset
REQ-026 rst_ni=0 at a rising edge SHALL force IDLE, remaining=0, wait counter=0, all outputs 0, including mid-EJECT (eject line drops next cycle).
REQ-027 req_i in the cycle reset releases SHALL be honoured per REQ-014.

Structure
REQ-028 Shared package vm_pkg SHALL hold the change-code type, coin values (NICKEL=5, DIME=10), max legal code 4, and the FSM state enum.
REQ-029 The wait counter SHALL be a sub-module ack_timer (clear, enable, expired output, parameter ACK_TIMEOUT).

Verification
REQ-030 change_i=3, ack 2 cycles after each eject -> dime then nickel, one GAP cycle between, done_o once, paid_o=15.
REQ-031 change_i=0 -> no eject, done_o pulses 1 cycle after req_i, paid_o=0.
REQ-032 change_i=6 -> err_o 1 cycle after req_i, no eject lines, busy_o high for 1 cycle.
REQ-033 change_i=4, ack withheld on second dime -> err_o after 15 wait cycles, paid_o=10, no done_o.
REQ-034 change_i=4, req_i re-asserted during EJECT and ack on timeout cycle -> two dimes, paid_o=20, single done_o, second req_i ignored.
REQ-035 change_i=2, rst_ni low during EJECT -> all outputs 0 next cycle, IDLE, subsequent change_i=1 dispenses one nickel.
